// File: rtl/dmem_resp_pkg.sv
// Shared encodings and constants for the data-memory responder.
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam int WORD_LSB = 2;
    localparam int CNT_W    = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data array: synchronous write, asynchronous read, no reset.
module dmem_array #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] index,
    input  logic [31:0]              wd,
    output logic [31:0]              rd
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[index] <= wd;
    end

    assign rd = mem[index];

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory target: latch request, optional wait states, one-cycle response.
// Wait states are compiled in only when DMEM_RESPONDER_WAITSTATE_EN is defined.
module dmem_responder
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int IDX_W = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dmem_responder: DEPTH must be a power of two >= 2");
    end
    if (WAIT < 0 || WAIT > 15) begin : g_bad_wait
        $error("dmem_responder: WAIT must be in 0..15");
    end

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] a_q, a_d;
    logic [31:0] wd_q, wd_d;
`ifdef DMEM_RESPONDER_WAITSTATE_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic        legal;
    logic        arr_we;
    logic [31:0] arr_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            a_q     <= '0;
            wd_q    <= '0;
`ifdef DMEM_RESPONDER_WAITSTATE_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            a_q     <= a_d;
            wd_q    <= wd_d;
`ifdef DMEM_RESPONDER_WAITSTATE_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        a_d     = a_q;
        wd_d    = wd_q;
`ifdef DMEM_RESPONDER_WAITSTATE_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d = we;
                    a_d  = a;
                    wd_d = wd;
`ifdef DMEM_RESPONDER_WAITSTATE_EN
                    if (WAIT > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT - 1);
                    end else begin
                        state_d = ST_RESP;
                    end
`else
                    state_d = ST_RESP;
`endif
                end
            end
`ifdef DMEM_RESPONDER_WAITSTATE_EN
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
`endif
            // RESP never accepts, guaranteeing an IDLE cycle between transactions.
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign legal  = (a_q[WORD_LSB-1:0] == '0) && (a_q[31:WORD_LSB] < 30'(DEPTH));
    assign ready  = (state_q == ST_RESP);
    assign busy   = (state_q != ST_IDLE);
    assign err    = ready && !legal;
    assign rd     = (ready && legal && !we_q) ? arr_rd : '0;
    // Commit lands on the edge that ends RESP; an async reset in RESP drops it.
    assign arr_we = ready && legal && we_q;

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (arr_we),
        .index (a_q[WORD_LSB +: IDX_W]),
        .wd    (wd_q),
        .rd    (arr_rd)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

    localparam int DEPTH   = 64;
    localparam int TB_WAIT = 2;
`ifdef DMEM_RESPONDER_WAITSTATE_EN
    localparam int W = TB_WAIT;
`else
    localparam int W = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] a   = '0;
    logic [31:0] wd  = '0;
    logic [31:0] rd;
    logic        ready, err, busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .WAIT(TB_WAIT)) dut (
        .clk   (clk),
        .reset (rst),
        .req   (req),
        .we    (we),
        .a     (a),
        .wd    (wd),
        .rd    (rd),
        .ready (ready),
        .err   (err),
        .busy  (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [31:0] addr);
        return (addr % 4 == 0) && (addr / 4 < DEPTH);
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic txn(input logic t_we, input logic [31:0] t_a, input logic [31:0] t_wd,
                       input bit keep_req);
        logic [31:0] exp_rd;
        bit          ok;
        ok     = is_legal(t_a);
        exp_rd = (ok && !t_we) ? model[t_a / 4] : 32'h0;
        req = 1'b1; we = t_we; a = t_a; wd = t_wd;
        @(posedge clk);
        for (int i = 0; i <= W; i++) begin
            @(negedge clk);
            chk("ready_timing", {31'b0, ready}, {31'b0, i == W});
            chk("busy_txn", {31'b0, busy}, 32'd1);
            if (i < W) begin
                we = 1'($urandom); a = $urandom; wd = $urandom;
            end
        end
        chk("err", {31'b0, err}, {31'b0, !ok});
        chk("rd", rd, exp_rd);
        if (ok && t_we) model[t_a / 4] = t_wd;
        if (keep_req) begin
            we = 1'($urandom); a = $urandom; wd = $urandom;
        end else begin
            req = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("idle_ready", {31'b0, ready}, 32'd0);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_rd", rd, 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 6)       return 32'($urandom_range(0, DEPTH - 1)) * 4;
        else if (sel == 6) return 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
        else if (sel == 7) return DEPTH * 4;
        else if (sel == 8) return (DEPTH - 1) * 4;
        else               return $urandom;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_rd", rd, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) txn(1'b1, 32'(i * 4), $urandom, 1'b0);

        // Reset during a write to 0x10 must abandon it without touching the array.
        req = 1'b1; we = 1'b1; a = 32'h10; wd = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ready", {31'b0, ready}, 32'd0);
        chk("midrst_err", {31'b0, err}, 32'd0);
        chk("midrst_rd", rd, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        txn(1'b0, 32'h10, 32'h0, 1'b0);

        txn(1'b1, 32'h08, 32'h12345678, 1'b0);
        txn(1'b0, 32'h08, 32'h0, 1'b0);
        txn(1'b1, 32'hFC, 32'hCAFEF00D, 1'b0);
        txn(1'b0, 32'hFC, 32'h0, 1'b0);

        txn(1'b1, 32'h100, 32'hFFFF0000, 1'b0);
        txn(1'b0, 32'h06, 32'h0, 1'b0);
        txn(1'b0, 32'h00, 32'h0, 1'b0);

        txn(1'b0, 32'h00, 32'h0, 1'b1);
        txn(1'b0, 32'h04, 32'h0, 1'b1);
        txn(1'b0, 32'h08, 32'h0, 1'b0);

        for (int i = 0; i < 60; i++)
            txn(1'($urandom), rand_addr(), $urandom, 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
